pdm_audio_out: RTL and testbench
================================

PDM_AUDIO_OUT -- requirements
Module: pdm_audio_out

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 2, giving the number of independent audio channels (1..8).
REQ-002 The block SHALL have parameter WIDTH, default 16, giving the signed sample width (8..24).
REQ-003 The block SHALL have parameter ORDER, default 2, selecting the modulator order; legal values are 1 or 2.
REQ-004 The block SHALL have parameter MUTE_BITS, default 24, giving the width of the post-unmute silence counter.
REQ-005 The block SHALL have parameter RAMP_SHIFT, default 4, where each gain step lasts 2^RAMP_SHIFT ce cycles.
REQ-006 clk_sys  input  1  system clock; all state updates on its rising edge.
REQ-007 reset_n  input  1  reset; asynchronous, active-low.
REQ-008 ce  input  1  clock enable; state advances only when ce=1.
REQ-009 mute_req  input  1  level request to silence outputs.
REQ-010 sample  input  CHANNELS*WIDTH  signed two's-complement samples; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-011 dac_out  output  CHANNELS  one-bit pulse-density stream per channel.
REQ-012 dac_oe  output  1  pad output enable; 0 means the top level tristates the audio pins.
REQ-013 gain  output  9  current ramp gain, 0..256.
REQ-014 state  output  2  FSM state: MUTE=0, WAIT=1, RAMP=2, RUN=3.

Function
REQ-015 On ce=1 the block SHALL latch sample into a hold register, converting each channel to offset binary by inverting its MSB.
REQ-016 Scaled input per channel SHALL be (offset_sample * gain) >> 8, WIDTH bits, with gain=256 passing the sample unchanged.
REQ-017 With ORDER=1, each channel SHALL keep a WIDTH-bit accumulator: {carry, acc} <= acc + x; dac_out = registered carry.
REQ-018 With ORDER=2, each channel SHALL keep two signed (WIDTH+3)-bit integrators: fb = dac_out ? 2^WIDTH : 0; i1 <= i1 + x - fb; i2 <= i2 + i1 - fb; dac_out <= (i2 >= 0).
REQ-019 Integrator arithmetic SHALL wrap modulo its width; no saturation logic is present.
REQ-020 FSM in MUTE: dac_oe=0, gain=0, integrators are held at 0, and dac_out=0; the FSM moves to WAIT on the first ce with mute_req=0.
REQ-021 FSM in WAIT: dac_oe=0; a MUTE_BITS-bit counter starts at 1, increments per ce, and the FSM moves to RAMP when the counter wraps to 0, so WAIT lasts exactly 2^MUTE_BITS-1 ce cycles.
REQ-022 FSM in RAMP: dac_oe=1; the modulators run; gain increments by 1 every 2^RAMP_SHIFT ce cycles; the FSM moves to RUN on the ce where gain reaches 256.
REQ-023 FSM in RUN: dac_oe=1 and gain=256.
REQ-024 mute_req=1 in any state SHALL force MUTE on the next ce, overriding all other transitions, including mid-WAIT and mid-RAMP.
REQ-025 When ce=0, all registers, including the sample hold register, SHALL keep their values.
REQ-026 Outputs SHALL be registered; dac_out responds to a new sample no earlier than 2 ce cycles after it is latched.

Reset
REQ-027 While reset_n=0: state=MUTE, dac_oe=0, dac_out=0, gain=0, and all counters, integrators and the hold register are 0.
REQ-028 After reset_n rises, the FSM SHALL leave MUTE only through the normal REQ-020 path.

Verification
REQ-029 Reset, then mute_req=0, MUTE_BITS=4, ce always 1 -> state=WAIT for exactly 15 cycles, then RAMP with dac_oe=1.
REQ-030 ORDER=1, WIDTH=16, RUN, sample=0x0000 -> offset 0x8000; dac_out has exactly 50% ones over 1024 cycles, alternating 0/1.
REQ-031 ORDER=2, RUN, sample=0x7FFF -> dac_out has at least 99.9% ones over 65536 cycles; sample=0x8000 -> at most 0.1% ones.
REQ-032 RAMP_SHIFT=2, sample=0x7FFF -> gain reaches 256 after exactly 1024 ce cycles in RAMP, then state=RUN.
REQ-033 mute_req pulsed for 1 ce with gain=100 in RAMP -> next cycle state=MUTE, gain=0, dac_oe=0, dac_out=0; WAIT restarts from count 1.
REQ-034 ce held 0 for 50 cycles in RUN with sample changing -> dac_out, integrators and gain frozen; reset_n pulsed low mid-RAMP -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pdm_audio_out.sv
// Multi-channel pulse-density audio DAC driver with click-free unmute:
// silent hold-off, linear gain ramp, then full-scale 1st/2nd-order modulation.
module pdm_audio_out #(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 16,
  parameter int ORDER      = 2,
  parameter int MUTE_BITS  = 24,
  parameter int RAMP_SHIFT = 4
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic                      ce,
  input  logic                      mute_req,
  input  logic [CHANNELS*WIDTH-1:0] sample,
  output logic [CHANNELS-1:0]       dac_out,
  output logic                      dac_oe,
  output logic [8:0]                gain,
  output logic [1:0]                state
);

  localparam logic [1:0] ST_MUTE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RAMP = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;
  localparam int RCW = (RAMP_SHIFT > 0) ? RAMP_SHIFT : 1;
  localparam int IW  = WIDTH + 3;

  logic [1:0]           state_reg, state_next;
  logic [MUTE_BITS-1:0] wait_cnt_reg, wait_cnt_next;
  logic [RCW-1:0]       ramp_cnt_reg, ramp_cnt_next;
  logic [8:0]           gain_reg, gain_next;
  logic                 ramp_step;
  logic                 run_next;

  assign ramp_step = (RAMP_SHIFT == 0) || (ramp_cnt_reg == {RCW{1'b1}});

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_MUTE;
      wait_cnt_reg <= '0;
      ramp_cnt_reg <= '0;
      gain_reg     <= '0;
    end else if (ce) begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      ramp_cnt_reg <= ramp_cnt_next;
      gain_reg     <= gain_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    ramp_cnt_next = '0;
    gain_next     = gain_reg;
    if (mute_req) begin
      state_next    = ST_MUTE;
      wait_cnt_next = '0;
      gain_next     = '0;
    end else begin
      case (state_reg)
        ST_MUTE: begin
          state_next    = ST_WAIT;
          wait_cnt_next = MUTE_BITS'(1);
          gain_next     = '0;
        end
        ST_WAIT: begin
          // Counter wraps to zero exactly as we hand over to the ramp.
          wait_cnt_next = wait_cnt_reg + MUTE_BITS'(1);
          if (&wait_cnt_reg) state_next = ST_RAMP;
        end
        ST_RAMP: begin
          ramp_cnt_next = ramp_cnt_reg + RCW'(1);
          if (ramp_step) begin
            gain_next = gain_reg + 9'd1;
            if (gain_reg == 9'd255) state_next = ST_RUN;
          end
        end
        default: gain_next = 9'd256;
      endcase
    end
  end

  // Modulators are cleared on the same ce that enters MUTE, so dac_out drops with dac_oe.
  always_comb begin
    dac_oe   = 1'b0;
    run_next = (state_next == ST_RAMP) || (state_next == ST_RUN);
    case (state_reg)
      ST_RAMP, ST_RUN: dac_oe = 1'b1;
      default:         dac_oe = 1'b0;
    endcase
  end

  assign state = state_reg;
  assign gain  = gain_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0] hold_reg;
      logic [WIDTH-1:0] x_reg;
      logic [WIDTH+8:0] prod;
      logic             dac_bit_reg;

      assign prod        = {9'd0, hold_reg} * {{WIDTH{1'b0}}, gain_reg};
      assign dac_out[gi] = dac_bit_reg;

      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
          hold_reg <= '0;
          x_reg    <= '0;
        end else if (ce) begin
          hold_reg <= {~sample[gi*WIDTH+WIDTH-1], sample[gi*WIDTH +: WIDTH-1]};
          x_reg    <= WIDTH'(prod >> 8);
        end
      end

      if (ORDER == 1) begin : g_o1
        logic [WIDTH-1:0] acc_reg;
        logic [WIDTH:0]   sum;
        assign sum = {1'b0, acc_reg} + {1'b0, x_reg};
        always_ff @(posedge clk_sys or negedge reset_n) begin
          if (!reset_n) begin
            acc_reg     <= '0;
            dac_bit_reg <= 1'b0;
          end else if (ce) begin
            if (run_next) begin
              acc_reg     <= sum[WIDTH-1:0];
              dac_bit_reg <= sum[WIDTH];
            end else begin
              acc_reg     <= '0;
              dac_bit_reg <= 1'b0;
            end
          end
        end
      end else begin : g_o2
        logic signed [IW-1:0] i1_reg, i2_reg, fb, x_ext;
        assign fb    = dac_bit_reg ? {3'b001, {WIDTH{1'b0}}} : '0;
        assign x_ext = {3'b000, x_reg};
        // Integrators wrap freely; the sign of i2 is the quantiser.
        always_ff @(posedge clk_sys or negedge reset_n) begin
          if (!reset_n) begin
            i1_reg      <= '0;
            i2_reg      <= '0;
            dac_bit_reg <= 1'b0;
          end else if (ce) begin
            if (run_next) begin
              i1_reg      <= i1_reg + x_ext - fb;
              i2_reg      <= i2_reg + i1_reg - fb;
              dac_bit_reg <= ~i2_reg[IW-1];
            end else begin
              i1_reg      <= '0;
              i2_reg      <= '0;
              dac_bit_reg <= 1'b0;
            end
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pdm_audio_out.sv
// Scoreboard bench for pdm_audio_out: second- and first-order instances share stimulus
// and are checked every clock against an arithmetic model of the unmute sequence.
module tb_pdm_audio_out;
  localparam int CH = 2;
  localparam int W  = 16;
  localparam int MB = 4;
  localparam int RS = 2;
  localparam int SW = CH * W;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          ce = 1'b0;
  logic          mute_req = 1'b0;
  logic [SW-1:0] sample = '0;
  logic [CH-1:0] dac2, dac1;
  logic          oe2, oe1;
  logic [8:0]    gain2, gain1;
  logic [1:0]    st2, st1;

  always #5 clk_sys = ~clk_sys;

  pdm_audio_out #(.CHANNELS(CH), .WIDTH(W), .ORDER(2), .MUTE_BITS(MB), .RAMP_SHIFT(RS)) dut2 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .mute_req(mute_req), .sample(sample),
    .dac_out(dac2), .dac_oe(oe2), .gain(gain2), .state(st2));

  pdm_audio_out #(.CHANNELS(CH), .WIDTH(W), .ORDER(1), .MUTE_BITS(MB), .RAMP_SHIFT(RS)) dut1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .mute_req(mute_req), .sample(sample),
    .dac_out(dac1), .dac_oe(oe1), .gain(gain1), .state(st1));

  typedef struct packed {
    logic [1:0]    st;
    logic [8:0]    gain;
    logic          oe;
    logic [CH-1:0] d2;
    logic [CH-1:0] d1;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  int     m_st, m_wait, m_ramp, m_gain;
  int     m_hold[CH], m_x[CH];
  longint m_i1[CH], m_i2[CH], m_acc[CH];
  bit     m_d2[CH], m_d1[CH];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic longint wrapw(input longint v);
    longint m;
    longint r;
    m = longint'(1) <<< (W + 3);
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  task automatic model_step(input bit rst, input bit cev, input bit mv, input logic [SW-1:0] smp);
    int ns;
    bit run;
    longint fb, n1, n2, s;
    logic [W-1:0] lane;
    int sv;
    if (!rst) begin
      m_st = 0; m_wait = 0; m_ramp = 0; m_gain = 0;
      for (int c = 0; c < CH; c++) begin
        m_hold[c] = 0; m_x[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_acc[c] = 0;
        m_d2[c] = 0; m_d1[c] = 0;
      end
      return;
    end
    if (!cev) return;
    if (mv) begin
      ns = 0; m_wait = 0; m_ramp = 0;
    end else begin
      case (m_st)
        0: begin ns = 1; m_wait = 0; end
        1: begin
          m_wait++;
          ns = (m_wait == (1 << MB) - 1) ? 2 : 1;
          m_ramp = 0;
        end
        2: begin
          m_ramp++;
          ns = ((m_ramp >> RS) >= 256) ? 3 : 2;
        end
        default: ns = 3;
      endcase
    end
    run = (ns >= 2);
    for (int c = 0; c < CH; c++) begin
      if (run) begin
        fb = m_d2[c] ? (longint'(1) <<< W) : 0;
        n1 = wrapw(m_i1[c] + m_x[c] - fb);
        n2 = wrapw(m_i2[c] + m_i1[c] - fb);
        m_d2[c] = (m_i2[c] >= 0);
        m_i1[c] = n1;
        m_i2[c] = n2;
        s = m_acc[c] + m_x[c];
        m_d1[c] = (s >= (longint'(1) <<< W));
        m_acc[c] = s % (longint'(1) <<< W);
      end else begin
        m_i1[c] = 0; m_i2[c] = 0; m_acc[c] = 0; m_d2[c] = 0; m_d1[c] = 0;
      end
      m_x[c] = (m_hold[c] * m_gain) / 256;
      lane = smp[c*W +: W];
      sv = $signed(lane);
      m_hold[c] = sv + (1 << (W - 1));
    end
    case (ns)
      2:       m_gain = m_ramp >> RS;
      3:       m_gain = 256;
      default: m_gain = 0;
    endcase
    m_st = ns;
  endtask

  task automatic step(input bit rst, input bit cev, input bit mv, input logic [SW-1:0] smp);
    exp_t e;
    @(negedge clk_sys);
    reset_n  = rst;
    ce       = cev;
    mute_req = mv;
    sample   = smp;
    model_step(rst, cev, mv, smp);
    e.st   = m_st[1:0];
    e.gain = m_gain[8:0];
    e.oe   = (m_st >= 2);
    for (int c = 0; c < CH; c++) begin
      e.d2[c] = m_d2[c];
      e.d1[c] = m_d1[c];
    end
    exp_q.push_back(e);
  endtask

  function automatic logic [SW-1:0] rnd_sample();
    return {16'($urandom), 16'($urandom)};
  endfunction

  // Monitor: every clock is one output transaction of both instances.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_sys);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state_o2", st2, e.st);
        chk("gain_o2", gain2, e.gain);
        chk("dac_oe_o2", oe2, e.oe);
        chk("dac_out_o2", dac2, e.d2);
        chk("state_o1", st1, e.st);
        chk("gain_o1", gain1, e.gain);
        chk("dac_oe_o1", oe1, e.oe);
        chk("dac_out_o1", dac1, e.d1);
      end
    end
  end

  task automatic count_wait(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (st2 == 2'd2) break;
      if (st2 == 2'd1) n++;
      step(1, 1, 0, rnd_sample());
    end
  endtask

  initial begin
    int  n_wait, n_ramp, ones0, ones1, alt, hit;
    bit  cev;
    logic prev0;

    for (int i = 0; i < 3; i++) step(0, 1'($urandom), 0, rnd_sample());
    for (int i = 0; i < 3; i++) step(1, 1, 1, rnd_sample());
    $display("txn reset+mute: state=%0d gain=%0d oe=%0d", st2, gain2, oe2);

    count_wait(n_wait);
    chk("wait_len", n_wait, (1 << MB) - 1);
    chk("ramp_entry_state", st2, 2);
    chk("ramp_entry_oe", oe2, 1);
    $display("txn unmute: wait cycles=%0d", n_wait);

    hit = 0;
    for (int i = 0; i < 3000; i++) begin
      if (gain2 == 9'd100) begin hit = 1; break; end
      step(1, ($urandom_range(0, 3) != 0), 0, rnd_sample());
    end
    chk("reach_gain100", hit, 1);
    step(1, 1, 1, rnd_sample());
    step(1, 1, 0, rnd_sample());
    chk("mute_state", st1, 0);
    chk("mute_gain", gain2, 0);
    chk("mute_oe", oe2, 0);
    chk("mute_dac", {dac2, dac1}, 0);
    $display("txn mute pulse at gain 100: state=%0d", st2);

    count_wait(n_wait);
    chk("rewait_len", n_wait, (1 << MB) - 1);

    n_ramp = 0;
    for (int i = 0; i < 6000; i++) begin
      if (st2 == 2'd3) break;
      cev = ($urandom_range(0, 3) != 0);
      if (st2 == 2'd2 && cev) n_ramp++;
      step(1, cev, 0, {16'h7FFF, 16'h7FFF});
    end
    chk("ramp_ce_cycles", n_ramp, 256 << RS);
    chk("run_state", st2, 3);
    chk("run_gain", gain1, 256);
    $display("txn ramp: ce cycles=%0d", n_ramp);

    for (int i = 0; i < 300; i++) step(1, ($urandom_range(0, 3) != 0), 0, rnd_sample());
    $display("txn run random: 300 cycles");
    for (int i = 0; i < 50; i++) step(1, 0, 0, rnd_sample());
    $display("txn ce low: 50 cycles");

    for (int i = 0; i < 8; i++) step(1, 1, 0, {16'h7FFF, 16'h0000});
    ones0 = 0; ones1 = 0; alt = 0; prev0 = dac1[0];
    for (int i = 0; i < 4096; i++) begin
      step(1, 1, 0, {16'h7FFF, 16'h0000});
      if (i < 1024) begin
        ones0 += int'(dac1[0]);
        if (dac1[0] != prev0) alt++;
        prev0 = dac1[0];
      end
      ones1 += int'(dac1[1]);
    end
    chk("o1_mid_ones", ones0, 512);
    chk("o1_mid_toggles", alt, 1024);
    chk("o1_full_density_ok", int'(ones1 >= 4092), 1);
    $display("txn density: mid ones=%0d toggles=%0d full ones=%0d/4096", ones0, alt, ones1);

    step(1, 1, 1, rnd_sample());
    count_wait(n_wait);
    for (int i = 0; i < 100; i++) step(1, 1, 0, rnd_sample());
    step(0, 1, 0, rnd_sample());
    #1;
    chk("async_rst_state", st2, 0);
    chk("async_rst_gain", gain1, 0);
    chk("async_rst_oe", {oe2, oe1}, 0);
    chk("async_rst_dac", {dac2, dac1}, 0);
    $display("txn async reset mid-ramp: state=%0d gain=%0d", st2, gain2);
    for (int i = 0; i < 3; i++) step(0, 1, 0, rnd_sample());
    for (int i = 0; i < 4; i++) step(1, 1, 0, rnd_sample());

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk_sys);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
